core_instr_fifo: RTL and testbench

- Per-core instruction queue directly downstream of the instruction arbiter. One instance per core, so the design has two instances.
- Accepts 32-bit instructions that the arbiter dispatches, buffers them in order, and presents them first-word-fall-through to the core fetch stage over a valid/ready handshake.
- Provides occupancy, almost-full, sticky overflow and high-water status so the arbiter and debug logic can observe back-pressure.

---
 rtl/instr_pkg.sv | 18 +
 rtl/core_instr_fifo_if.sv | 21 ++
 rtl/core_instr_fifo_storage.sv | 23 ++
 rtl/core_instr_fifo.sv | 98 +++++++++
 tb/tb_core_instr_fifo.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/instr_pkg.sv
// Instruction format shared by the arbiter and the per-core instruction queues.
package instr_pkg;

    localparam int unsigned INSTR_W      = 32;

    localparam int unsigned FORCE_BIT    = 27;
    localparam int unsigned CORE_SEL_BIT = 26;
    localparam int unsigned SRC_TAG_BIT  = 23;
    localparam int unsigned DST_TAG_BIT  = 22;

    localparam int unsigned DST_ADDR_MSB = 21;
    localparam int unsigned DST_ADDR_LSB = 11;
    localparam int unsigned SRC_ADDR_MSB = 10;
    localparam int unsigned SRC_ADDR_LSB = 0;

    typedef logic [INSTR_W-1:0] instr_t;

endpackage

// File: rtl/core_instr_fifo_if.sv
// Valid/ready write (arbiter) and read (core fetch) channels of the instruction queue.
interface core_instr_fifo_if #(
    parameter int unsigned DATA_W = instr_pkg::INSTR_W
);
    logic              wr_valid;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              rd_ready;

    modport master (
        output wr_valid, wr_data, rd_ready,
        input  wr_ready, rd_valid, rd_data
    );

    modport slave (
        input  wr_valid, wr_data, rd_ready,
        output wr_ready, rd_valid, rd_data
    );
endinterface

// File: rtl/core_instr_fifo_storage.sv
// Register-file storage: one synchronous write port, one asynchronous read port, no reset.
module fifo_storage #(
    parameter  int unsigned DATA_W = 32,
    parameter  int unsigned DEPTH  = 8,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/core_instr_fifo.sv
// Per-core first-word-fall-through instruction queue with occupancy and back-pressure status.
module core_instr_fifo
    import instr_pkg::*;
#(
    parameter  int unsigned DATA_W    = INSTR_W,
    parameter  int unsigned DEPTH     = 8,
    parameter  int unsigned AF_THRESH = 6,
    localparam int unsigned ADDR_W    = $clog2(DEPTH),
    localparam int unsigned CNT_W     = ADDR_W + 1
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     flush,
    core_instr_fifo_if.slave         bus,
    output logic [CNT_W-1:0]         count,
    output logic                     empty,
    output logic                     full,
    output logic                     almost_full,
    output logic                     overflow,
    output logic [CNT_W-1:0]         high_water
);
    logic [CNT_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  high_water_q, high_water_d;
    logic              overflow_q, overflow_d;
    logic              push, pop;
    logic [DATA_W-1:0] head_data;

    // Status comes only from registered count, so no input-to-output combinational path.
    assign empty       = (count_q == '0);
    assign full        = (count_q == CNT_W'(DEPTH));
    assign almost_full = (count_q >= CNT_W'(AF_THRESH));

    assign bus.wr_ready = !full;
    assign bus.rd_valid = !empty;
    assign bus.rd_data  = empty ? '0 : head_data;

    assign count      = count_q;
    assign overflow   = overflow_q;
    assign high_water = high_water_q;

    assign push = bus.wr_valid && !full;
    assign pop  = bus.rd_ready && !empty;

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        overflow_d   = overflow_q;
        high_water_d = high_water_q;
        if (flush) begin
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            count_d      = '0;
            overflow_d   = 1'b0;
            high_water_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            if (bus.wr_valid && full) overflow_d = 1'b1;
            if (count_d > high_water_q) high_water_d = count_d;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            high_water_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            high_water_q <= high_water_d;
        end
    end

    fifo_storage #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_storage (
        .clk   (clk),
        .we    (push && !flush),
        .waddr (wr_ptr_q[ADDR_W-1:0]),
        .wdata (bus.wr_data),
        .raddr (rd_ptr_q[ADDR_W-1:0]),
        .rdata (head_data)
    );
endmodule

// File: tb/tb_core_instr_fifo.sv
// Scoreboard bench for core_instr_fifo: accepted writes are queued, pops compared against the queue head.
module tb_core_instr_fifo;
    localparam int unsigned DEPTH     = 8;
    localparam int unsigned AF_THRESH = 6;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        flush = 1'b0;
    logic [3:0]  count;
    logic        empty, full, almost_full, overflow;
    logic [3:0]  high_water;

    core_instr_fifo_if #(.DATA_W(32)) bus ();

    core_instr_fifo #(
        .DATA_W    (32),
        .DEPTH     (DEPTH),
        .AF_THRESH (AF_THRESH)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .flush       (flush),
        .bus         (bus),
        .count       (count),
        .empty       (empty),
        .full        (full),
        .almost_full (almost_full),
        .overflow    (overflow),
        .high_water  (high_water)
    );

    always #5 clk = ~clk;

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    logic [31:0] sb[$];
    int unsigned m_count = 0;
    int unsigned m_hw    = 0;
    logic        m_ovf   = 1'b0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic check_status(input string tag);
        logic [31:0] exp_data;
        exp_data = (m_count > 0) ? sb[0] : 32'h0;
        chk_eq({tag, ".count"},       32'(count),       m_count);
        chk_eq({tag, ".empty"},       32'(empty),       32'(m_count == 0));
        chk_eq({tag, ".full"},        32'(full),        32'(m_count == DEPTH));
        chk_eq({tag, ".almost_full"}, 32'(almost_full), 32'(m_count >= AF_THRESH));
        chk_eq({tag, ".overflow"},    32'(overflow),    32'(m_ovf));
        chk_eq({tag, ".high_water"},  32'(high_water),  m_hw);
        chk_eq({tag, ".rd_valid"},    32'(bus.rd_valid), 32'(m_count > 0));
        chk_eq({tag, ".wr_ready"},    32'(bus.wr_ready), 32'(m_count < DEPTH));
        chk_eq({tag, ".rd_data"},     bus.rd_data,      exp_data);
    endtask

    task automatic model_reset();
        sb.delete();
        m_count = 0;
        m_hw    = 0;
        m_ovf   = 1'b0;
    endtask

    // Called at a falling edge; drives inputs, predicts the next rising edge, returns at the next falling edge.
    task automatic step(input logic wv, input logic [31:0] wd, input logic rr, input logic fl);
        logic        do_push, do_pop;
        logic [31:0] exp_head;
        bus.wr_valid = wv;
        bus.wr_data  = wd;
        bus.rd_ready = rr;
        flush        = fl;
        #1;
        do_push = wv && (m_count < DEPTH) && !fl;
        do_pop  = rr && (m_count > 0) && !fl;
        if (do_pop) begin
            exp_head = sb.pop_front();
            chk_eq("pop_data", bus.rd_data, exp_head);
        end
        if (fl) begin
            model_reset();
        end else begin
            if (wv && m_count == DEPTH) m_ovf = 1'b1;
            if (do_push) sb.push_back(wd);
            m_count = m_count + (do_push ? 1 : 0) - (do_pop ? 1 : 0);
            if (m_count > m_hw) m_hw = m_count;
        end
        @(posedge clk);
        @(negedge clk);
        bus.wr_valid = 1'b0;
        bus.rd_ready = 1'b0;
        flush        = 1'b0;
    endtask

    task automatic drain();
        int unsigned guard;
        guard = 0;
        while (m_count > 0 && guard < 4 * DEPTH) begin
            step(1'b0, 32'h0, 1'b1, 1'b0);
            guard++;
        end
        chk_eq("drain_done", 32'(m_count), 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.wr_valid = 1'b0;
        bus.wr_data  = '0;
        bus.rd_ready = 1'b0;
        resetn       = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_status("reset");
        resetn = 1'b1;
        @(negedge clk);

        // Three pushes, no reads.
        for (int i = 1; i <= 3; i++) step(1'b1, 32'(i), 1'b0, 1'b0);
        check_status("t1");
        chk_eq("t1.head", bus.rd_data, 32'h1);
        drain();

        // Fill to full, overflow attempt, drain.
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 32'hA0 + 32'(i), 1'b0, 1'b0);
            check_status("fill");
        end
        chk_eq("t2.full", 32'(full), 32'h1);
        step(1'b1, 32'hFF, 1'b0, 1'b0);
        chk_eq("t2.overflow", 32'(overflow), 32'h1);
        chk_eq("t2.count", 32'(count), 32'h8);
        for (int i = 0; i < 8; i++) begin
            chk_eq("t2.order", bus.rd_data, 32'hA0 + 32'(i));
            step(1'b0, 32'h0, 1'b1, 1'b0);
        end
        check_status("t2.drained");
        step(1'b0, 32'h0, 1'b0, 1'b1);
        check_status("t2.flushed");

        // Steady-state push+pop at count 4 across pointer wrap.
        for (int i = 0; i < 4; i++) step(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 32'h200 + 32'(i), 1'b1, 1'b0);
            check_status("wrap");
        end
        chk_eq("t3.high_water", 32'(high_water), 32'h4);
        drain();

        // Empty with simultaneous write and read: push only.
        chk_eq("t4.rd_valid_before", 32'(bus.rd_valid), 32'h0);
        step(1'b1, 32'h0800_0000, 1'b1, 1'b0);
        chk_eq("t4.rd_valid", 32'(bus.rd_valid), 32'h1);
        chk_eq("t4.rd_data", bus.rd_data, 32'h0800_0000);
        drain();

        // Five entries with overflow set, then flush with write and read.
        for (int i = 0; i < 9; i++) step(1'b1, 32'h300 + 32'(i), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
        check_status("t5.pre");
        chk_eq("t5.ovf_pre", 32'(overflow), 32'h1);
        step(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1);
        check_status("t5.post");
        chk_eq("t5.overflow", 32'(overflow), 32'h0);
        chk_eq("t5.high_water", 32'(high_water), 32'h0);
        step(1'b1, 32'h55, 1'b0, 1'b0);
        chk_eq("t5.not_stored", bus.rd_data, 32'h55);
        drain();

        // Asynchronous reset with five entries.
        for (int i = 0; i < 5; i++) step(1'b1, 32'h400 + 32'(i), 1'b0, 1'b0);
        check_status("t6.pre");
        #2;
        resetn = 1'b0;
        #1;
        model_reset();
        chk_eq("t6.count", 32'(count), 32'h0);
        chk_eq("t6.rd_valid", 32'(bus.rd_valid), 32'h0);
        chk_eq("t6.rd_data", bus.rd_data, 32'h0);
        @(negedge clk);
        check_status("t6.held");
        resetn = 1'b1;
        @(negedge clk);

        // Random traffic with occasional flush.
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 39) == 0));
            check_status("rand");
        end
        drain();
        check_status("final");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
